// File: rtl/pipelined_adder.sv
// Segmented carry-ripple adder: one SEG-bit slice per stage with valid/ready flow control.
// Define PIPELINED_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_adder #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SEG   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             out_valid,
   input  logic             out_ready
`ifdef PIPELINED_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned N = WIDTH / SEG;

   logic [WIDTH-1:0] a_q [N];
   logic [WIDTH-1:0] b_q [N];
   logic [WIDTH-1:0] s_q [N];
   logic             c_q [N];
   logic             v_q [N];
   logic             advance;

`ifdef PIPELINED_ADDER_OVF_EN
   logic ovf_q;
`endif

   assign advance   = !v_q[N-1] || out_ready;
   assign in_ready  = advance;
   assign s         = s_q[N-1];
   assign cout      = c_q[N-1];
   assign out_valid = v_q[N-1];

`ifdef PIPELINED_ADDER_OVF_EN
   assign ovf = ovf_q;
`endif

   for (genvar k = 0; k < N; k++) begin : g_stage
      logic [WIDTH-1:0] a_src;
      logic [WIDTH-1:0] b_src;
      logic [WIDTH-1:0] s_src;
      logic [WIDTH-1:0] s_d;
      logic             c_src;
      logic             v_src;
      logic [SEG:0]     seg_sum;

      if (k == 0) begin : g_head
         assign a_src = a;
         assign b_src = b;
         assign s_src = '0;
         assign c_src = cin;
         assign v_src = in_valid;
      end else begin : g_body
         assign a_src = a_q[k-1];
         assign b_src = b_q[k-1];
         assign s_src = s_q[k-1];
         assign c_src = c_q[k-1];
         assign v_src = v_q[k-1];
      end

      // Full operands travel with the transaction; each stage only rewrites its own slice of s.
      always_comb begin
         seg_sum = {1'b0, a_src[k*SEG +: SEG]} + {1'b0, b_src[k*SEG +: SEG]}
                   + {{SEG{1'b0}}, c_src};
         s_d = s_src;
         s_d[k*SEG +: SEG] = seg_sum[SEG-1:0];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q[k] <= 1'b0;
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
         end else if (advance) begin
            v_q[k] <= v_src;
            a_q[k] <= a_src;
            b_q[k] <= b_src;
            s_q[k] <= s_d;
            c_q[k] <= seg_sum[SEG];
         end
      end

`ifdef PIPELINED_ADDER_OVF_EN
      if (k == N - 1) begin : g_ovf
         logic ovf_d;
         // Same-sign operands with a differently-signed sum equals carry-in XOR carry-out of the MSB.
         assign ovf_d = (a_src[WIDTH-1] == b_src[WIDTH-1]) && (s_d[WIDTH-1] != a_src[WIDTH-1]);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else if (advance) begin
               ovf_q <= ovf_d;
            end
         end
      end
`endif
   end

endmodule
